dm_arbiter: RTL

Two-master arbiter for the single data memory port between the pipeline CPU's data side and a debug/loader requester (memory preload, state inspection). The CPU has priority by default. A starvation counter forces one debug access through after a bounded wait, and the arbiter stalls the CPU for that cycle. The block sits between the CPU data interface and `dm`, and forwards the memory's write enable, address, write data and DMType unchanged.

---
 rtl/dm_arb_pkg.sv | 19 +
 rtl/dm_arbiter_if.sv | 47 ++++
 rtl/dm_arb_age_counter.sv | 31 +++
 rtl/dm_arbiter.sv | 84 ++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its memory port.
package dm_arb_pkg;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_t;

    localparam int unsigned WAIT_W      = 4;
    localparam int unsigned STALL_CNT_W = 16;

    // DMType encodings shared with dm
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF   = 3'b001;
    localparam logic [2:0] DM_HALF_U = 3'b010;
    localparam logic [2:0] DM_BYTE   = 3'b011;
    localparam logic [2:0] DM_BYTE_U = 3'b100;

endpackage

// File: rtl/dm_arbiter_if.sv
// CPU, debug and memory-side signals of the data-memory arbiter.
interface dm_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_dmtype;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [2:0]        dbg_dmtype;
    logic              dbg_gnt;
    logic [DATA_W-1:0] dbg_rdata;

    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_din;
    logic [2:0]        dm_dmtype;
    logic [DATA_W-1:0] dm_dout;

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_dmtype,
        input  dbg_gnt, dbg_rdata,
        input  dm_we, dm_addr, dm_din, dm_dmtype,
        output dm_dout
    );

    // Arbiter
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_dmtype,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_dmtype,
        output dbg_gnt, dbg_rdata,
        output dm_we, dm_addr, dm_din, dm_dmtype,
        input  dm_dout
    );
endinterface

// File: rtl/dm_arb_age_counter.sv
// Counts consecutive denied debug cycles and flags when the next cycle must be forced.
module dm_arb_age_counter
    import dm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              dbg_req,
    input  logic              dbg_gnt,
    output logic              force_next,
    output logic              clear,
    output logic [WAIT_W-1:0] wait_cnt
);

    logic denied;

    assign denied     = dbg_req & ~dbg_gnt;
    assign clear      = ~denied;
    assign force_next = denied && (wait_cnt == WAIT_W'(STARVE_LIMIT - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            wait_cnt <= '0;
        else if (clear)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the data memory port: CPU first, debug forced through after a bounded wait.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    dm_arbiter_if.slave            bus,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    arb_state_t        state, state_n;
    logic              gnt_raw;
    logic              dbg_gnt;
    logic              cpu_stall;
    logic              force_next;
    logic              cnt_clear;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_din;

    dm_arb_age_counter #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_age (
        .clk       (clk),
        .rstn      (rstn),
        .dbg_req   (bus.dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_next(force_next),
        .clear     (cnt_clear),
        .wait_cnt  (wait_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= CPU_PRI;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        gnt_raw = 1'b0;
        case (state)
            CPU_PRI: begin
                gnt_raw = bus.dbg_req & ~bus.cpu_req;
                if (force_next)
                    state_n = DBG_FORCE;
            end
            DBG_FORCE: begin
                gnt_raw = bus.dbg_req;
                state_n = CPU_PRI;
            end
            default: state_n = CPU_PRI;
        endcase
    end

    // Reset masks grant and stall combinationally so nothing reaches memory mid-reset
    assign dbg_gnt   = gnt_raw & rstn;
    assign cpu_stall = bus.cpu_req & dbg_gnt;

    assign mux_addr = dbg_gnt ? bus.dbg_addr  : bus.cpu_addr;
    assign mux_din  = dbg_gnt ? bus.dbg_wdata : bus.cpu_wdata;

    assign bus.dbg_gnt   = dbg_gnt;
    assign bus.cpu_stall = cpu_stall;
    assign bus.dm_we     = rstn & (dbg_gnt ? bus.dbg_we : (bus.cpu_we & bus.cpu_req));
    assign bus.dm_addr   = mux_addr;
    assign bus.dm_din    = mux_din;
    assign bus.dm_dmtype = dbg_gnt ? bus.dbg_dmtype : bus.cpu_dmtype;
    assign bus.cpu_rdata = bus.dm_dout;
    assign bus.dbg_rdata = bus.dm_dout;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            stall_cycles <= '0;
        else if (cpu_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule
